// File: rtl/rf_array_p_if.sv
// rf_array_p_if: bus bundle for the rf_array_p register file.
//   wr_en/wr_addr/wr_data : write request, sampled on every rising edge
//   rd_addr               : NRD packed read addresses, port k at [k*AW +: AW]
//   rd_hold               : freezes the registered read addresses (stall)
//   rd_data               : NRD packed read words, port k at [k*DW +: DW]
//   clr_busy              : clear sweep in progress, file unusable
// master drives requests and consumes read data; slave is the register file.
interface rf_array_p_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 5,
    parameter int unsigned NRD = 2
) ();
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NRD*AW-1:0] rd_addr;
    logic              rd_hold;
    logic [NRD*DW-1:0] rd_data;
    logic              clr_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rd_hold,
        input  rd_data, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rd_hold,
        output rd_data, clr_busy
    );
endinterface

// File: rtl/rf_array_p.sv
// rf_array_p: parametrised multi-read, single-write register file for the
// mips789 decode stage.
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : rf_array_p_if.slave (write port, NRD read ports, clr_busy)
// Writes are registered for one cycle before committing to the array; the
// registered write is bypassed to any read port addressing the same entry,
// so a write sampled at edge N is visible to reads sampled at the same edge.
// After reset a sequencer zeroes every entry, one per cycle, before the
// file becomes usable.
module rf_array_p #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    rf_array_p_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;

    logic [DW-1:0] mem [DEPTH];

    logic          w_en_q;
    logic [AW-1:0] w_addr_q;
    logic [DW-1:0] w_data_q;

    logic [AW-1:0] ra_q [NRD];

    logic clearing;
    logic wr_to_zero;

    assign clearing     = (state == CLEAR);
    assign wr_to_zero   = ZERO_REG && (bus.wr_addr == '0);
    assign bus.clr_busy = clearing;

    // Clear sequencer: reset parks it at entry 0; sweep ends on the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) begin
                state <= RUN;
            end
        end
    end

    // Write stage: requests during reset, the sweep, or to a hard-wired zero
    // entry are dropped here so they never reach the array or the bypass.
    always_ff @(posedge clk) begin
        w_en_q   <= bus.wr_en && !rst && !clearing && !wr_to_zero;
        w_addr_q <= bus.wr_addr;
        w_data_q <= bus.wr_data;
    end

    // Array update: sweep zeroing, otherwise the staged write commits.
    // Nothing is written on a reset edge, which discards a pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[cnt] <= '0;
            end else if (w_en_q) begin
                mem[w_addr_q] <= w_data_q;
            end
        end
    end

    // Registered read addresses, frozen while rd_hold is high.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NRD; k++) begin
            if (rst) begin
                ra_q[k] <= '0;
            end else if (!bus.rd_hold) begin
                ra_q[k] <= bus.rd_addr[k*AW +: AW];
            end
        end
    end

    // Read ports: clear masks everything, then the zero entry, then the
    // bypass of the staged write, then the array itself.
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (clearing) begin
                bus.rd_data[k*DW +: DW] = '0;
            end else if (ZERO_REG && (ra_q[k] == '0)) begin
                bus.rd_data[k*DW +: DW] = '0;
            end else if (w_en_q && (w_addr_q == ra_q[k])) begin
                bus.rd_data[k*DW +: DW] = w_data_q;
            end else begin
                bus.rd_data[k*DW +: DW] = mem[ra_q[k]];
            end
        end
    end
endmodule

// File: tb/tb_rf_array_p.sv
// tb_rf_array_p: self-checking bench for rf_array_p.
// Three instances: default (DW32/AW5/NRD2/ZERO_REG1), a small one
// (AW3/NRD1/ZERO_REG0) and a three-port one (AW5/NRD3/ZERO_REG1).
module tb_rf_array_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    rf_array_p_if #(.DW(32), .AW(5), .NRD(2)) bus0 ();
    rf_array_p_if #(.DW(32), .AW(3), .NRD(1)) bus1 ();
    rf_array_p_if #(.DW(32), .AW(5), .NRD(3)) bus2 ();

    rf_array_p #(.DW(32), .AW(5), .NRD(2), .ZERO_REG(1'b1)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
    rf_array_p #(.DW(32), .AW(3), .NRD(1), .ZERO_REG(1'b0)) u1 (.clk(clk), .rst(rst1), .bus(bus1));
    rf_array_p #(.DW(32), .AW(5), .NRD(3), .ZERO_REG(1'b1)) u2 (.clk(clk), .rst(rst2), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference for u0: a register file where every write is applied the
    // moment it is sampled and reads return the contents seen by the
    // addresses sampled at the same edge.
    logic [31:0] mm  [32];
    logic [4:0]  mra [2];
    bit          model_on = 1'b0;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        bit          h;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input int k);
        return (mra[k] == 5'd0) ? 32'h0 : mm[mra[k]];
    endfunction

    task automatic model_step();
        if (bus0.wr_en && bus0.wr_addr != 5'd0) mm[bus0.wr_addr] = bus0.wr_data;
        if (!bus0.rd_hold) begin
            mra[0] = bus0.rd_addr[4:0];
            mra[1] = bus0.rd_addr[9:5];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_step();
        #1;
    endtask

    task automatic drv0(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r0, input logic [4:0] r1, input bit h);
        bus0.wr_en   = we;
        bus0.wr_addr = wa;
        bus0.wr_data = wd;
        bus0.rd_addr = {r1, r0};
        bus0.rd_hold = h;
    endtask

    function automatic logic busy(input int d);
        case (d)
            0:       return bus0.clr_busy;
            1:       return bus1.clr_busy;
            default: return bus2.clr_busy;
        endcase
    endfunction

    // Counts edges from reset release until clr_busy drops (bounded).
    // On u0, injects a write at sweep cycle wr_at that must be dropped.
    task automatic sweep(input int d, input int wr_at, output int len);
        len = -1;
        for (int c = 1; c <= 300; c++) begin
            if (d == 0 && c == wr_at)     drv0(1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b0);
            if (d == 0 && c == wr_at + 1) drv0(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0);
            tick();
            if (busy(d) == 1'b0) begin
                len = c;
                break;
            end
            if (d == 0 && c == wr_at + 2)
                check("clear_rd_masked", 128'(bus0.rd_data), 128'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  1'b0, 32'h0,        32'hDEADBEEF};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd7,  1'b0, 32'h11,       32'h11};
        tbl[6]  = '{1'b1, 5'd9,  32'h99,       5'd7,  5'd9,  1'b0, 32'h11,       32'h99};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd1,  1'b1, 32'h11,       32'h99};
        tbl[8]  = '{1'b1, 5'd7,  32'h22,       5'd9,  5'd1,  1'b1, 32'h22,       32'h99};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd1,  1'b1, 32'h22,       32'h99};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  1'b0, 32'h99,       32'h22};
        tbl[11] = '{1'b1, 5'd12, 32'h1,        5'd12, 5'd12, 1'b0, 32'h1,        32'h1};
        tbl[12] = '{1'b1, 5'd12, 32'h2,        5'd12, 5'd12, 1'b0, 32'h2,        32'h2};
        tbl[13] = '{1'b1, 5'd12, 32'h3,        5'd12, 5'd3,  1'b0, 32'h3,        32'h0};
        tbl[14] = '{1'b1, 5'd31, 32'h31,       5'd12, 5'd31, 1'b0, 32'h3,        32'h31};
        tbl[15] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  1'b0, 32'h31,       32'h0};
        tbl[16] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd12, 1'b0, 32'hDEADBEEF, 32'h3};

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        drv0(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.rd_addr = '0; bus1.rd_hold = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.rd_addr = '0; bus2.rd_hold = 1'b0;

        // ---------------- u0: reset, clear sweep, dropped write ----------------
        repeat (3) tick();
        check("rst_clr_busy", 128'(bus0.clr_busy), 128'(1));
        check("rst_rd_data", 128'(bus0.rd_data), 128'(0));
        rst0 = 1'b0;
        sweep(0, 10, len);
        check("clr_len_32", 128'(len), 128'(32));

        for (int i = 0; i < 32; i++) mm[i] = 32'h0;
        mra[0] = 5'd0; mra[1] = 5'd0;
        model_on = 1'b1;
        for (int a = 0; a < 32; a++) begin
            drv0(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0);
            tick();
            check((a == 3) ? "clr_dropped_wr3" : "clr_zero", 128'(bus0.rd_data), 128'(0));
        end

        // ---------------- u0: directed vectors ----------------
        for (int i = 0; i < 17; i++) begin
            drv0(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1, tbl[i].h);
            tick();
            check($sformatf("vec%0d_p0", i), 128'(bus0.rd_data[31:0]),  128'(tbl[i].e0));
            check($sformatf("vec%0d_p1", i), 128'(bus0.rd_data[63:32]), 128'(tbl[i].e1));
        end

        // ---------------- u0: randomized against the model ----------------
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] wa, r0, r1;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            drv0(1'($urandom_range(0, 1)), wa, $urandom, r0, r1, ($urandom_range(0, 3) == 0));
            tick();
            check("rand_p0", 128'(bus0.rd_data[31:0]),  128'(model_rd(0)));
            check("rand_p1", 128'(bus0.rd_data[63:32]), 128'(model_rd(1)));
        end
        model_on = 1'b0;
        drv0(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

        // ---------------- u1: AW=3, no hard-wired zero ----------------
        check("u1_rst_busy", 128'(bus1.clr_busy), 128'(1));
        rst1 = 1'b0;
        sweep(1, -5, len);
        check("u1_clr_len_8", 128'(len), 128'(8));
        bus1.wr_en = 1'b1; bus1.wr_addr = 3'd0; bus1.wr_data = 32'hFFFFFFFF; bus1.rd_addr = 3'd0;
        tick();
        check("u1_r0_bypass", 128'(bus1.rd_data), 128'(32'hFFFFFFFF));
        bus1.wr_en = 1'b0;
        tick();
        check("u1_r0_commit", 128'(bus1.rd_data), 128'(32'hFFFFFFFF));
        bus1.wr_en = 1'b1; bus1.wr_addr = 3'd7; bus1.wr_data = 32'h77; bus1.rd_addr = 3'd5;
        tick();
        check("u1_r5_zero", 128'(bus1.rd_data), 128'(0));
        bus1.wr_en = 1'b0; bus1.rd_addr = 3'd7;
        tick();
        check("u1_r7_top", 128'(bus1.rd_data), 128'(32'h77));

        // ---------------- u2: three ports, reset mid-clear ----------------
        rst2 = 1'b0;
        sweep(2, -5, len);
        check("u2_clr_len_32", 128'(len), 128'(32));
        for (int a = 1; a < 32; a++) begin
            bus2.wr_en = 1'b1; bus2.wr_addr = 5'(a); bus2.wr_data = 32'hA000_0000 | 32'(a);
            tick();
        end
        bus2.wr_en = 1'b0;
        bus2.rd_addr = {5'd1, 5'd31, 5'd20};
        tick();
        check("u2_preload", 128'(bus2.rd_data), 128'({32'hA000_0001, 32'hA000_001F, 32'hA000_0014}));
        rst2 = 1'b1;
        repeat (2) tick();
        rst2 = 1'b0;
        repeat (19) tick();
        check("u2_mid_busy", 128'(bus2.clr_busy), 128'(1));
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        sweep(2, -5, len);
        check("u2_restart_len_32", 128'(len), 128'(32));
        for (int a = 0; a < 32; a++) begin
            bus2.rd_addr = {5'((a + 2) % 32), 5'((a + 1) % 32), 5'(a)};
            tick();
            check("u2_zero_3port", 128'(bus2.rd_data), 128'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_array_p.md
# rf_array_p

Parametrised general-purpose register file for the mips789 decode stage. It is the next generation of the 2-read/1-write register array. Data width, depth and read-port count are parameters, and register 0 can optionally be hard-wired to zero. It keeps the registered-write, write-through bypass and read-address hold behaviour. It adds a hardware clear sequencer that zeroes every entry after reset, so simulation no longer depends on an `initial` block.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; DEPTH = 2**AW entries
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 reads as zero and writes to it are dropped

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request this cycle
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_hold  in  1  when 1, registered read addresses are not updated (pipeline stall)
- rd_data  out  NRD*DW  read data; port k occupies bits [k*DW +: DW]
- clr_busy  out  1  clear sequencer active; the file is not usable while high

## Operation
- Write stage: every clock edge captures {w_en_q, w_addr_q, w_data_q} from {wr_en, wr_addr, wr_data}. w_en_q is forced to 0 when any of these holds:
  - ZERO_REG=1 and wr_addr==0
  - the sequencer is in CLEAR
  - rst is high
- Commit: on the edge after capture, if w_en_q=1 then array[w_addr_q] <= w_data_q.
- Read-address registers: ra_q[k] <= rd_addr[k] on each edge when rd_hold=0 and rst=0. They hold their value when rd_hold=1. They reset to 0.
- rd_data[k] is combinational from the registered state. Priority for each port:
  1. If the sequencer is in CLEAR, the output is 0.
  2. Else if ZERO_REG=1 and ra_q[k]==0, the output is 0.
  3. Else if w_en_q=1 and w_addr_q==ra_q[k], the output is w_data_q (bypass).
  4. Otherwise the output is array[ra_q[k]].
- All ports are independent. Any number of ports may share an address.
- Clear sequencer FSM, states CLEAR and RUN, with an AW-bit counter cnt:
  - rst=1: state <= CLEAR, cnt <= 0. No array write happens in that cycle.
  - CLEAR with rst=0: array[cnt] <= 0 and cnt <= cnt+1. When cnt==DEPTH-1, state <= RUN on the same edge.
  - RUN: remains in RUN until rst. cnt is don't-care.
- clr_busy = (state==CLEAR).
- While clr_busy=1, wr_en is ignored and dropped. It is not queued.
- Reset mid-clear restarts the sweep at entry 0.
- A write pending in the write stage when rst asserts is discarded.
- Array contents are not reset directly. Only the sequencer zeroes them.

## Timing
- Reset values: rd_data = 0 on all ports, clr_busy = 1, ra_q = 0, w_en_q = 0.
- clr_busy stays high for exactly DEPTH cycles after the first edge with rst=0. The default is 32 cycles.
- Read latency: rd_addr sampled at edge N gives rd_data valid during cycle N+1, up to edge N+1.
- Write visibility, for wr_en sampled at edge N:
  - visible via bypass during cycle N+1 to any port whose ra_q matches;
  - visible from the array from cycle N+2 onward.
  - A read of the same address sampled at edge N therefore returns the new data.
- Back-to-back writes to the same address: the last write wins. The bypass always shows the most recent captured write.
- rd_hold=1 at edge N: ra_q keeps its cycle-N value. rd_data still tracks commits and bypass for that held address.
- Simultaneous commit and bypass to the same address produce identical data, so there is no hazard.
- There is no X-propagation path: every output is defined from the cycle after rst.

## Test plan
- Reset and clear: hold rst for 3 cycles, then release. Expect clr_busy=1 for exactly 32 cycles, then 0. Afterwards, reading entries 1..31 on both ports returns 0x00000000.
- Bypass: in cycle N, write addr 5 = 0xDEADBEEF and set rd_addr port0=5 and port1=5. Expect 0xDEADBEEF on both ports in cycle N+1. Expect the same value in cycle N+3 with no further write.
- Zero register: write addr 0 = 0xFFFFFFFF, then read addr 0. Expect 0. With ZERO_REG=0 and AW=3, expect 0xFFFFFFFF, and clr_busy lasts 8 cycles.
- Hold: set port0 = addr 7, which holds 0x11. Assert rd_hold and drive rd_addr=9. Expect port0 to stay 0x11. Write addr 7 = 0x22 while held; expect 0x22 on the next cycle. Release hold; expect addr 9's value on the next cycle.
- Writes during clear: drive wr_en=1, addr 3 = 0x55 on cycle 10 of the sweep. After clr_busy falls, entry 3 reads 0.
- Reset mid-clear: assert rst at sweep cycle 20. After release, clr_busy lasts a full 32 cycles. With NRD=3, all three ports read 0 for entries 0..31.
